// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and datapath widths.
// Used by both the receiver and transmitter.
package uart_pkg;

    localparam int unsigned UART_DATA_WIDTH = 8;
    localparam int unsigned UART_DIV_WIDTH  = 12;

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        PARITY_BIT,
        STOP_BIT
    } uart_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Host-side interface of the UART receiver: received byte, status flags and
// runtime line configuration.
interface uart_rx_if;
    import uart_pkg::*;

    logic [UART_DATA_WIDTH-1:0] data;
    logic                       valid;
    logic                       parity_err;
    logic                       frame_err;
    logic                       busy;
    logic [UART_DIV_WIDTH-1:0]  baud_divider;
    logic                       parity_en;
    logic                       parity_type_odd;

    // The receiver is the master: it produces bytes and consumes configuration.
    modport master (
        output data,
        output valid,
        output parity_err,
        output frame_err,
        output busy,
        input  baud_divider,
        input  parity_en,
        input  parity_type_odd
    );

    modport slave (
        input  data,
        input  valid,
        input  parity_err,
        input  frame_err,
        input  busy,
        output baud_divider,
        output parity_en,
        output parity_type_odd
    );

endinterface

// File: rtl/uart_sync_edge.sv
// Two-flop synchronizer for an idle-high asynchronous input, with a registered
// copy of the synchronized level for falling-edge detection.
module uart_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic fall
);

    logic [1:0] sync_q;
    logic       prev_q;

    // Reset to 1 so a line that is already idle does not look like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], din};
            prev_q <= sync_q[1];
        end
    end

    assign sync = sync_q[1];
    assign fall = prev_q & ~sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, optional even/odd parity, one stop bit,
// runtime baud divider; samples each bit at mid-period.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx,
    uart_rx_if.master bus
);

    localparam int unsigned      PosW    = $clog2(DATA_WIDTH);
    localparam logic [PosW-1:0]  LastPos = PosW'(DATA_WIDTH - 1);

    logic rx_s;
    logic rx_fall;

    uart_sync_edge u_sync (
        .clk (clk),
        .rst (rst),
        .din (rx),
        .sync(rx_s),
        .fall(rx_fall)
    );

    uart_state_t state_q, state_d;

    logic [UART_DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [UART_DIV_WIDTH-1:0] div_q, div_d;
    logic                      par_en_q, par_en_d;
    logic                      odd_q, odd_d;
    logic [PosW-1:0]           bit_pos_q, bit_pos_d;
    logic [DATA_WIDTH-1:0]     shift_q, shift_d;
    logic                      par_acc_q, par_acc_d;
    logic                      par_err_q, par_err_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      perr_out_q, perr_out_d;
    logic                      ferr_out_q, ferr_out_d;

    logic at_half;
    logic at_full;
    logic start_frame;
    logic sample_start;
    logic sample_data;
    logic sample_par;
    logic sample_stop;

    assign at_half = (cnt_q == (div_q >> 1));
    assign at_full = (cnt_q == div_q);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (rx_fall) state_d = START_BIT;
            end
            START_BIT: begin
                // A line that is high again at mid-start was only a glitch.
                if (sample_start) state_d = rx_s ? IDLE : DATA_BITS;
            end
            DATA_BITS: begin
                if (sample_data && bit_pos_q == LastPos) begin
                    state_d = par_en_q ? PARITY_BIT : STOP_BIT;
                end
            end
            PARITY_BIT: begin
                if (sample_par) state_d = STOP_BIT;
            end
            STOP_BIT: begin
                if (sample_stop) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- FSM outputs
    always_comb begin
        start_frame  = 1'b0;
        sample_start = 1'b0;
        sample_data  = 1'b0;
        sample_par   = 1'b0;
        sample_stop  = 1'b0;
        unique case (state_q)
            IDLE:       start_frame  = rx_fall;
            START_BIT:  sample_start = at_half;
            DATA_BITS:  sample_data  = at_full;
            PARITY_BIT: sample_par   = at_full;
            STOP_BIT:   sample_stop  = at_full;
            default:    start_frame  = 1'b0;
        endcase
        bus.busy = (state_q != IDLE);
    end

    // ---------------------------------------------------------------- datapath
    always_comb begin
        cnt_d      = cnt_q + 12'd1;
        div_d      = div_q;
        par_en_d   = par_en_q;
        odd_d      = odd_q;
        bit_pos_d  = bit_pos_q;
        shift_d    = shift_q;
        par_acc_d  = par_acc_q;
        par_err_d  = par_err_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;

        // Restarting at mid-start re-aligns every later sample to mid-bit.
        if (state_q == IDLE || sample_start || sample_data || sample_par || sample_stop) begin
            cnt_d = '0;
        end

        if (start_frame) begin
            div_d     = bus.baud_divider;
            par_en_d  = bus.parity_en;
            odd_d     = bus.parity_type_odd;
            bit_pos_d = '0;
            par_acc_d = 1'b0;
            par_err_d = 1'b0;
        end

        if (sample_data) begin
            shift_d[bit_pos_q] = rx_s;
            par_acc_d          = par_acc_q ^ rx_s;
            bit_pos_d          = bit_pos_q + 1'b1;
        end

        if (sample_par) begin
            par_err_d = rx_s ^ par_acc_q ^ odd_q;
        end

        if (sample_stop) begin
            data_d     = shift_q;
            valid_d    = 1'b1;
            perr_out_d = par_err_q;
            ferr_out_d = ~rx_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            div_q      <= '0;
            par_en_q   <= 1'b0;
            odd_q      <= 1'b0;
            bit_pos_q  <= '0;
            shift_q    <= '0;
            par_acc_q  <= 1'b0;
            par_err_q  <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            par_en_q   <= par_en_d;
            odd_q      <= odd_d;
            bit_pos_q  <= bit_pos_d;
            shift_q    <= shift_d;
            par_acc_q  <= par_acc_d;
            par_err_q  <= par_err_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
        end
    end

    assign bus.data       = data_q;
    assign bus.valid      = valid_q;
    assign bus.parity_err = perr_out_q;
    assign bus.frame_err  = ferr_out_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a table of single frames, hand-written
// corner sequences, and a long-divider back-to-back stream, checked by a scoreboard.
module tb_uart_rx;

    logic clk = 1'b0;
    logic rst;
    logic rx;

    uart_rx_if bus ();

    uart_rx #(
        .DATA_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx (rx),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       perr;
        logic       ferr;
    } exp_t;

    typedef struct {
        logic [7:0] d;
        logic       pen;
        logic       odd;
        logic       pbit;
        logic       stop;
        logic [7:0] exp_d;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[8];

    int errors = 0;
    int checks = 0;
    int n_valid = 0;
    int cyc = 0;
    int last_start_cyc = 0;
    bit lat_check = 1'b0;
    bit prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic drive_bit(input logic b, input int n);
        rx = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                              input logic stop, input int n);
        last_start_cyc = cyc;
        drive_bit(1'b0, n);
        for (int i = 0; i < 8; i++) drive_bit(d[i], n);
        if (pen) drive_bit(pbit, n);
        drive_bit(stop, n);
    endtask

    task automatic push_exp(input logic [7:0] d, input logic perr, input logic ferr);
        exp_t e;
        e.d    = d;
        e.perr = perr;
        e.ferr = ferr;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int max_cyc);
        int k = 0;
        while (exp_q.size() != 0 && k < max_cyc) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic set_cfg(input int d, input logic pen, input logic odd);
        bus.baud_divider    = 12'(d);
        bus.parity_en       = pen;
        bus.parity_type_odd = odd;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: every valid must match the head of the scoreboard.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (prev_valid) check("valid_one_cycle", bus.valid, 1'b0);
            if (bus.valid) begin
                n_valid++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got data=0x%0h, expected no valid", bus.data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("data", bus.data, mon_e.d);
                    check("parity_err", bus.parity_err, mon_e.perr);
                    check("frame_err", bus.frame_err, mon_e.ferr);
                    check("busy_low_with_valid", bus.busy, 1'b0);
                    if (lat_check) begin
                        checks++;
                        if (cyc - last_start_cyc < 50 || cyc - last_start_cyc > 52) begin
                            errors++;
                            $display("FAIL latency: got %0d clocks, expected 50..52",
                                     cyc - last_start_cyc);
                        end
                        lat_check = 1'b0;
                    end
                end
            end
        end
        prev_valid = bus.valid;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb;
        logic [7:0] bytes[16];
        int n0;
        bit seen;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};
        vecs[2] = '{8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0};
        vecs[3] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[4] = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[5] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[6] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1};
        vecs[7] = '{8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};

        rst = 1'b1;
        rx  = 1'b1;
        set_cfg(4, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("reset_data", bus.data, 8'h00);
        check("reset_valid", bus.valid, 1'b0);
        check("reset_parity_err", bus.parity_err, 1'b0);
        check("reset_frame_err", bus.frame_err, 1'b0);
        check("reset_busy", bus.busy, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_bit(1'b1, 3);

        for (int i = 0; i < 8; i++) begin
            set_cfg(4, vecs[i].pen, vecs[i].odd);
            push_exp(vecs[i].exp_d, vecs[i].exp_perr, vecs[i].exp_ferr);
            lat_check = (i == 0);
            send_frame(vecs[i].d, vecs[i].pen, vecs[i].pbit, vecs[i].stop, 5);
            drive_bit(1'b1, 10);
            wait_drain(50);
        end

        // One-clock glitch: start detected, then rejected at mid-start.
        set_cfg(4, 1'b0, 1'b0);
        drive_bit(1'b0, 1);
        rx = 1'b1;
        seen = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.busy) seen = 1'b1;
        end
        check("glitch_busy_seen", seen, 1'b1);
        check("glitch_busy_low", bus.busy, 1'b0);
        @(posedge clk);
        #1;
        drive_bit(1'b1, 10);

        // Framing error followed by a held-low break.
        n0 = n_valid;
        push_exp(8'h3C, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 5);
        drive_bit(1'b0, 100);
        wait_drain(10);
        check("break_single_valid", n_valid - n0, 1);
        check("break_busy_low", bus.busy, 1'b0);
        drive_bit(1'b1, 10);
        push_exp(8'h81, 1'b0, 1'b0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 5);
        drive_bit(1'b1, 10);
        wait_drain(50);

        // Reset during bit 4 of 0xC3, then a clean 0xFF.
        drive_bit(1'b0, 5);
        rb = 8'hC3;
        for (int i = 0; i < 4; i++) drive_bit(rb[i], 5);
        drive_bit(rb[4], 2);
        @(negedge clk);
        check("midframe_busy", bus.busy, 1'b1);
        #1;
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        check("midrst_data", bus.data, 8'h00);
        check("midrst_valid", bus.valid, 1'b0);
        check("midrst_parity_err", bus.parity_err, 1'b0);
        check("midrst_frame_err", bus.frame_err, 1'b0);
        check("midrst_busy", bus.busy, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_bit(1'b1, 20);
        @(negedge clk);
        check("post_rst_idle", bus.busy, 1'b0);
        @(posedge clk);
        #1;
        push_exp(8'hFF, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 5);
        drive_bit(1'b1, 10);
        wait_drain(50);

        // Back-to-back stream at 115200 baud / 50 MHz, odd parity.
        set_cfg(433, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 16; i++) begin
            push_exp(bytes[i], 1'b0, 1'b0);
            send_frame(bytes[i], 1'b1, ~(^bytes[i]), 1'b1, 434);
        end
        drive_bit(1'b1, 20);
        wait_drain(1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
